vga_rect_sched: RTL and testbench

Rectangle overlay scheduler for the 640x480 VGA path on TD_CLK. Holds N_RECT rectangle descriptors written through a valid/ready configuration port into shadow registers, and copies them to active registers only during vertical blanking so that a frame never tears. Each active pixel is tested against every enabled rectangle. Exactly one colour is chosen per pixel: the lowest-index hit, or the background colour when nothing hits. The result drives the 4-bit-per-channel RGB outputs.

---
 rtl/vga_rect_sched_if.sv | 22 ++
 rtl/vga_rect_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_vga_rect_sched.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_sched_if.sv
// Configuration/commit port of the VGA rectangle overlay scheduler.
// The master side writes descriptors and requests commits; the slave side is the scheduler.
interface vga_rect_sched_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_idx;
  logic [2:0]  cfg_field;
  logic [12:0] cfg_data;
  logic        commit_req;
  logic        commit_ack;
  logic        busy;

  modport master (
    output cfg_valid, cfg_idx, cfg_field, cfg_data, commit_req,
    input  cfg_ready, commit_ack, busy
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_field, cfg_data, commit_req,
    output cfg_ready, commit_ack, busy
  );
endinterface

// File: rtl/vga_rect_sched.sv
// Rectangle overlay scheduler: shadow descriptors copied to active set in vblank, 2-stage pixel path.
// Optional macro VGA_SCHED_BORDER_EN: rectangles hit only on their 1-pixel outline.
module vga_rect_sched #(
  parameter int N_RECT = 4,
  parameter int CW     = 11
) (
  input  logic          TD_CLK,
  input  logic          reset,
  input  logic [CW-1:0] x_pos,
  input  logic [CW-1:0] y_pos,
  input  logic          de,
  input  logic          vblank,
  vga_rect_sched_if.slave cfg,
  output logic [3:0]    rgb_r,
  output logic [3:0]    rgb_g,
  output logic [3:0]    rgb_b,
  output logic          rgb_de,
  output logic          hit,
  output logic [2:0]    hit_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_COPY = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  copy_idx_r;
  logic        cfg_ready_r, busy_r, commit_ack_r;
  logic        wr_fire_s;

  logic [CW-1:0] sh_x0_r [N_RECT];
  logic [CW-1:0] sh_x1_r [N_RECT];
  logic [CW-1:0] sh_y0_r [N_RECT];
  logic [CW-1:0] sh_y1_r [N_RECT];
  logic [11:0]   sh_col_r [N_RECT];
  logic          sh_en_r  [N_RECT];
  logic [11:0]   sh_bg_r;

  logic [CW-1:0] act_x0_r [N_RECT];
  logic [CW-1:0] act_x1_r [N_RECT];
  logic [CW-1:0] act_y0_r [N_RECT];
  logic [CW-1:0] act_y1_r [N_RECT];
  logic [11:0]   act_col_r [N_RECT];
  logic          act_en_r  [N_RECT];
  logic [11:0]   act_bg_r;

  logic [N_RECT-1:0] cmp_s, hit1_r;
  logic              de1_r;
  logic              win_hit_s;
  logic [2:0]        win_idx_s;
  logic [11:0]       win_col_s;
  logic [11:0]       rgb_q_r;
  logic              rgb_de_r, hit_r;
  logic [2:0]        hit_idx_r;

  assign wr_fire_s      = cfg.cfg_valid && cfg_ready_r;
  assign cfg.cfg_ready  = cfg_ready_r;
  assign cfg.busy       = busy_r;
  assign cfg.commit_ack = commit_ack_r;

  // Control state, copy pointer and control outputs registered from the next state
  always_ff @(posedge TD_CLK or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      copy_idx_r   <= 4'd0;
      cfg_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      commit_ack_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      copy_idx_r   <= (state_r == ST_COPY) ? copy_idx_r + 4'd1 : 4'd0;
      cfg_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r       <= (state_nxt_s == ST_PEND) || (state_nxt_s == ST_COPY);
      commit_ack_r <= (state_nxt_s == ST_ACK);
    end
  end

  // Next-state logic; COPY ends after the background slot regardless of vblank
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg.commit_req) state_nxt_s = ST_PEND;
        else                state_nxt_s = ST_IDLE;
      end
      ST_PEND: begin
        if (vblank) state_nxt_s = ST_COPY;
        else        state_nxt_s = ST_PEND;
      end
      ST_COPY: begin
        if (copy_idx_r == 4'(N_RECT)) state_nxt_s = ST_ACK;
        else                          state_nxt_s = ST_COPY;
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Shadow descriptor writes; indices beyond N_RECT match no slot and are dropped
  always_ff @(posedge TD_CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_RECT; i++) begin
        sh_x0_r[i]  <= {CW{1'b0}};
        sh_x1_r[i]  <= {CW{1'b0}};
        sh_y0_r[i]  <= {CW{1'b0}};
        sh_y1_r[i]  <= {CW{1'b0}};
        sh_col_r[i] <= 12'h000;
        sh_en_r[i]  <= 1'b0;
      end
      sh_bg_r <= 12'h000;
    end else if (wr_fire_s) begin
      if (cfg.cfg_field == 3'd5) sh_bg_r <= cfg.cfg_data[11:0];
      for (int i = 0; i < N_RECT; i++) begin
        if (cfg.cfg_idx == 3'(i)) begin
          case (cfg.cfg_field)
            3'd0: sh_x0_r[i] <= CW'(cfg.cfg_data[10:0]);
            3'd1: sh_x1_r[i] <= CW'(cfg.cfg_data[10:0]);
            3'd2: sh_y0_r[i] <= CW'(cfg.cfg_data[10:0]);
            3'd3: sh_y1_r[i] <= CW'(cfg.cfg_data[10:0]);
            3'd4: begin
              sh_col_r[i] <= cfg.cfg_data[11:0];
              sh_en_r[i]  <= cfg.cfg_data[12];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Active set: one descriptor per COPY cycle, background in the final slot
  always_ff @(posedge TD_CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_RECT; i++) begin
        act_x0_r[i]  <= {CW{1'b0}};
        act_x1_r[i]  <= {CW{1'b0}};
        act_y0_r[i]  <= {CW{1'b0}};
        act_y1_r[i]  <= {CW{1'b0}};
        act_col_r[i] <= 12'h000;
        act_en_r[i]  <= 1'b0;
      end
      act_bg_r <= 12'h000;
    end else if (state_r == ST_COPY) begin
      for (int i = 0; i < N_RECT; i++) begin
        if (copy_idx_r == 4'(i)) begin
          act_x0_r[i]  <= sh_x0_r[i];
          act_x1_r[i]  <= sh_x1_r[i];
          act_y0_r[i]  <= sh_y0_r[i];
          act_y1_r[i]  <= sh_y1_r[i];
          act_col_r[i] <= sh_col_r[i];
          act_en_r[i]  <= sh_en_r[i];
        end
      end
      if (copy_idx_r == 4'(N_RECT)) act_bg_r <= sh_bg_r;
    end
  end

  // Per-rectangle inclusive bounds test; inverted bounds can never satisfy it
  always_comb begin
    cmp_s = {N_RECT{1'b0}};
    for (int i = 0; i < N_RECT; i++) begin
      cmp_s[i] = act_en_r[i] &&
                 (x_pos >= act_x0_r[i]) && (x_pos <= act_x1_r[i]) &&
                 (y_pos >= act_y0_r[i]) && (y_pos <= act_y1_r[i]);
`ifdef VGA_SCHED_BORDER_EN
      cmp_s[i] = cmp_s[i] &&
                 ((x_pos == act_x0_r[i]) || (x_pos == act_x1_r[i]) ||
                  (y_pos == act_y0_r[i]) || (y_pos == act_y1_r[i]));
`endif
    end
  end

  // Stage 1 register
  always_ff @(posedge TD_CLK or negedge reset) begin
    if (!reset) begin
      hit1_r <= {N_RECT{1'b0}};
      de1_r  <= 1'b0;
    end else begin
      hit1_r <= cmp_s;
      de1_r  <= de;
    end
  end

  // Priority encode: scan downwards so the lowest index hit is the last to win
  always_comb begin
    win_hit_s = 1'b0;
    win_idx_s = 3'd0;
    win_col_s = act_bg_r;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      win_hit_s = hit1_r[i] ? 1'b1         : win_hit_s;
      win_idx_s = hit1_r[i] ? 3'(i)        : win_idx_s;
      win_col_s = hit1_r[i] ? act_col_r[i] : win_col_s;
    end
  end

  // Stage 2 register: blank everything outside active video
  always_ff @(posedge TD_CLK or negedge reset) begin
    if (!reset) begin
      rgb_q_r   <= 12'h000;
      rgb_de_r  <= 1'b0;
      hit_r     <= 1'b0;
      hit_idx_r <= 3'd0;
    end else begin
      rgb_q_r   <= de1_r ? win_col_s : 12'h000;
      rgb_de_r  <= de1_r;
      hit_r     <= de1_r && win_hit_s;
      hit_idx_r <= de1_r ? win_idx_s : 3'd0;
    end
  end

  assign rgb_r   = rgb_q_r[11:8];
  assign rgb_g   = rgb_q_r[7:4];
  assign rgb_b   = rgb_q_r[3:0];
  assign rgb_de  = rgb_de_r;
  assign hit     = hit_r;
  assign hit_idx = hit_idx_r;

endmodule

// File: tb/tb_vga_rect_sched.sv
// Scoreboard bench for vga_rect_sched: expected pixels queued at drive time, compared 2 cycles later.
// Honours VGA_SCHED_BORDER_EN in its reference model when the macro is defined.
module tb_vga_rect_sched;
  localparam int N = 4;

  logic        TD_CLK = 1'b0;
  logic        reset;
  logic [10:0] x_pos, y_pos;
  logic        de, vblank;
  logic [3:0]  rgb_r, rgb_g, rgb_b;
  logic        rgb_de, hit;
  logic [2:0]  hit_idx;

  vga_rect_sched_if cfg_bus();

  vga_rect_sched #(.N_RECT(N), .CW(11)) dut (
    .TD_CLK(TD_CLK), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .de(de), .vblank(vblank), .cfg(cfg_bus.slave),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .rgb_de(rgb_de), .hit(hit), .hit_idx(hit_idx)
  );

  always #5 TD_CLK = ~TD_CLK;

  typedef struct { int due; logic [16:0] exp; } sb_t;
  sb_t sb_q[$];
  int  cyc = 0;
  int  n_total = 0;
  int  n_bad = 0;

  // reference descriptors: shadow (m_s*) and displayed (m_a*)
  int          m_sx0[N], m_sx1[N], m_sy0[N], m_sy1[N];
  logic [11:0] m_scol[N];
  logic        m_sen[N];
  logic [11:0] m_sbg;
  int          m_ax0[N], m_ax1[N], m_ay0[N], m_ay1[N];
  logic [11:0] m_acol[N];
  logic        m_aen[N];
  logic [11:0] m_abg;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge TD_CLK) cyc <= cyc + 1;

  // output monitor: pop the entry due this cycle
  always @(negedge TD_CLK) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      check_val("pix", {15'd0, hit, hit_idx, rgb_r, rgb_g, rgb_b, rgb_de}, {15'd0, e.exp});
    end
  end

  function automatic logic [16:0] mk(input logic h, input logic [2:0] i, input logic [11:0] c, input logic d);
    return {h, i, c, d};
  endfunction

  function automatic logic [16:0] model_pix(input int x, input int y, input logic d);
    logic [16:0] r;
    logic        in;
    if (!d) return 17'd0;
    r = mk(1'b0, 3'd0, m_abg, 1'b1);
    for (int i = N - 1; i >= 0; i--) begin
      in = m_aen[i] && x >= m_ax0[i] && x <= m_ax1[i] && y >= m_ay0[i] && y <= m_ay1[i];
`ifdef VGA_SCHED_BORDER_EN
      in = in && (x == m_ax0[i] || x == m_ax1[i] || y == m_ay0[i] || y == m_ay1[i]);
`endif
      if (in) r = mk(1'b1, 3'(i), m_acol[i], 1'b1);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge TD_CLK);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y, input logic d, input logic [16:0] exp);
    x_pos = 11'(x);
    y_pos = 11'(y);
    de    = d;
    sb_q.push_back('{cyc + 2, exp});
    tick();
  endtask

  task automatic pix(input int x, input int y, input logic d);
    drive_pix(x, y, d, model_pix(x, y, d));
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sx0[i] = 0; m_sx1[i] = 0; m_sy0[i] = 0; m_sy1[i] = 0; m_scol[i] = 12'h000; m_sen[i] = 1'b0;
      m_ax0[i] = 0; m_ax1[i] = 0; m_ay0[i] = 0; m_ay1[i] = 0; m_acol[i] = 12'h000; m_aen[i] = 1'b0;
    end
    m_sbg = 12'h000;
    m_abg = 12'h000;
  endtask

  task automatic model_commit();
    for (int i = 0; i < N; i++) begin
      m_ax0[i] = m_sx0[i]; m_ax1[i] = m_sx1[i]; m_ay0[i] = m_sy0[i]; m_ay1[i] = m_sy1[i];
      m_acol[i] = m_scol[i]; m_aen[i] = m_sen[i];
    end
    m_abg = m_sbg;
  endtask

  task automatic cfg_wr(input int idx, input int fld, input logic [12:0] d);
    check_val("cfg_ready_idle", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idx   = 3'(idx);
    cfg_bus.cfg_field = 3'(fld);
    cfg_bus.cfg_data  = d;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    if (fld == 5) m_sbg = d[11:0];
    else if (idx < N) begin
      case (fld)
        0: m_sx0[idx] = int'(d[10:0]);
        1: m_sx1[idx] = int'(d[10:0]);
        2: m_sy0[idx] = int'(d[10:0]);
        3: m_sy1[idx] = int'(d[10:0]);
        4: begin m_scol[idx] = d[11:0]; m_sen[idx] = d[12]; end
        default: ;
      endcase
    end
  endtask

  task automatic set_rect(input int idx, input int x0, input int x1, input int y0, input int y1,
                          input logic [11:0] col, input logic en);
    cfg_wr(idx, 0, 13'(x0));
    cfg_wr(idx, 1, 13'(x1));
    cfg_wr(idx, 2, 13'(y0));
    cfg_wr(idx, 3, 13'(y1));
    cfg_wr(idx, 4, {en, col});
  endtask

  // commit with vblank already high; ack must appear N+3 edges after raising commit_req
  task automatic commit_vb();
    int n;
    de = 1'b0;
    vblank = 1'b1;
    cfg_bus.commit_req = 1'b1;
    n = 0;
    do begin
      tick();
      cfg_bus.commit_req = 1'b0;
      n++;
    end while (!cfg_bus.commit_ack && n < 50);
    check_val("ack_latency", 32'(n), 32'(N + 3));
    tick();
    check_val("ack_one_cycle", {31'd0, cfg_bus.commit_ack}, 32'd0);
    check_val("ready_after_ack", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    vblank = 1'b0;
    model_commit();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rgb"}, {20'd0, rgb_r, rgb_g, rgb_b}, 32'd0);
    check_val({tag, "_de_hit_idx"}, {27'd0, rgb_de, hit, hit_idx}, 32'd0);
    check_val({tag, "_ack_busy_rdy"}, {29'd0, cfg_bus.commit_ack, cfg_bus.busy, cfg_bus.cfg_ready}, 32'd1);
  endtask

  initial begin
    int acks;
    reset = 1'b0;
    x_pos = 11'd0; y_pos = 11'd0; de = 1'b0; vblank = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_idx = 3'd0; cfg_bus.cfg_field = 3'd0;
    cfg_bus.cfg_data = 13'd0; cfg_bus.commit_req = 1'b0;
    model_clear();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // empty configuration: everything black, no hits
    for (int i = 0; i < 64; i++) pix(i * 10, i * 7, 1'b1);
    pix(639, 479, 1'b1);

    // single rectangle, filled edges inclusive
    set_rect(0, 100, 200, 50, 80, 12'hF00, 1'b1);
    pix(100, 50, 1'b1);               // shadow only: still background
    commit_vb();
    drive_pix(100, 50, 1'b1, mk(1'b1, 3'd0, 12'hF00, 1'b1));
    drive_pix(201, 50, 1'b1, mk(1'b0, 3'd0, 12'h000, 1'b1));
    drive_pix(200, 80, 1'b1, mk(1'b1, 3'd0, 12'hF00, 1'b1));
    drive_pix(99, 50, 1'b1, mk(1'b0, 3'd0, 12'h000, 1'b1));
    drive_pix(100, 81, 1'b1, mk(1'b0, 3'd0, 12'h000, 1'b1));
    drive_pix(150, 60, 1'b0, 17'd0);

    // overlap priority, inverted bounds, background, out-of-range index
    cfg_wr(0, 5, 13'h0123);
    set_rect(0, 250, 350, 250, 350, 12'h0F0, 1'b1);
    set_rect(1, 280, 400, 280, 400, 12'h00F, 1'b1);
    set_rect(2, 500, 400, 0, 479, 12'hFFF, 1'b1);
    cfg_wr(5, 4, {1'b1, 12'hEEE});
    commit_vb();
    drive_pix(300, 300, 1'b1, mk(1'b1, 3'd0, 12'h0F0, 1'b1));
    drive_pix(380, 380, 1'b1, mk(1'b1, 3'd1, 12'h00F, 1'b1));
    drive_pix(10, 10, 1'b1, mk(1'b0, 3'd0, 12'h123, 1'b1));
    drive_pix(450, 100, 1'b1, mk(1'b0, 3'd0, 12'h123, 1'b1));
    for (int i = 0; i < 40; i++) pix($urandom_range(639, 0), $urandom_range(479, 0), 1'b1);
    cfg_wr(0, 4, {1'b0, 12'h0F0});
    commit_vb();
    drive_pix(300, 300, 1'b1, mk(1'b1, 3'd1, 12'h00F, 1'b1));

    // commit during active video waits in PEND; writes refused meanwhile
    cfg_wr(1, 4, {1'b1, 12'hABC});
    cfg_bus.commit_req = 1'b1;
    tick();
    cfg_bus.commit_req = 1'b0;
    check_val("busy_pend", {31'd0, cfg_bus.busy}, 32'd1);
    check_val("ready_pend", {31'd0, cfg_bus.cfg_ready}, 32'd0);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_idx = 3'd3; cfg_bus.cfg_field = 3'd4;
    cfg_bus.cfg_data = {1'b1, 12'hFFF};
    for (int i = 0; i < 4; i++) pix(300, 300, 1'b1);
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.commit_req = 1'b1;
    pix(0, 0, 1'b1);
    cfg_bus.commit_req = 1'b0;
    check_val("busy_still", {31'd0, cfg_bus.busy}, 32'd1);
    de = 1'b0;
    vblank = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acks += int'(cfg_bus.commit_ack);
    end
    check_val("ack_count", 32'(acks), 32'd1);
    vblank = 1'b0;
    model_commit();
    drive_pix(300, 300, 1'b1, mk(1'b1, 3'd1, 12'hABC, 1'b1));
    pix(0, 0, 1'b1);

    // asynchronous reset in the middle of COPY
    x_pos = 11'd300; y_pos = 11'd300; de = 1'b1;
    repeat (3) tick();
    vblank = 1'b1;
    cfg_bus.commit_req = 1'b1;
    tick();
    cfg_bus.commit_req = 1'b0;
    repeat (3) tick();
    check_val("busy_copy", {31'd0, cfg_bus.busy}, 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset_mid_copy");
    tick();
    reset = 1'b1;
    model_clear();
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      acks += int'(cfg_bus.commit_ack);
    end
    check_val("no_ack_after_reset", 32'(acks), 32'd0);
    vblank = 1'b0;
    pix(300, 300, 1'b1);
    commit_vb();
    pix(300, 300, 1'b1);

    // outline vs filled behaviour
    set_rect(0, 10, 20, 10, 20, 12'h5A5, 1'b1);
    cfg_wr(0, 5, 13'h0111);
    commit_vb();
    drive_pix(15, 10, 1'b1, mk(1'b1, 3'd0, 12'h5A5, 1'b1));
`ifdef VGA_SCHED_BORDER_EN
    drive_pix(15, 15, 1'b1, mk(1'b0, 3'd0, 12'h111, 1'b1));
`else
    drive_pix(15, 15, 1'b1, mk(1'b1, 3'd0, 12'h5A5, 1'b1));
`endif
    pix(20, 20, 1'b1);
    pix(21, 15, 1'b1);

    de = 1'b0;
    repeat (4) tick();
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
